// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction timer.
// State codes, BCD digit width and LFSR seed/taps.
package rt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DELAY   = 4'd1,
    ST_MEASURE = 4'd2,
    ST_SCORE   = 4'd3,
    ST_FOUL    = 4'd4
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter for the reaction score.
// Clear has priority; counting stops at 999.
module bcd_counter3
  import rt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] d0,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d2
);

  logic sat;

  assign sat = (d0 == 4'd9) &&
               (d1 == 4'd9) &&
               (d2 == 4'd9);

  // Cascaded decimal increment with saturation
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
    end else if (inc && !sat) begin
      if (d0 != 4'd9) begin
        d0 <= d0 + 4'd1;
      end else begin
        d0 <= '0;
        if (d1 != 4'd9) begin
          d1 <= d1 + 4'd1;
        end else begin
          d1 <= '0;
          d2 <= d2 + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/reaction_game_controller.sv
// Reaction timer sequencer: game FSM, ms tick,
// random delay, button conditioning and score.
module reaction_game_controller
  import rt_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int DELAY_MIN_MS  = 1000,
  parameter int SCORE_HOLD_MS = 3000,
  parameter int FOUL_HOLD_MS  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       KEY,
  output logic [3:0]       out_state,
  output logic             en_idle,
  output logic             en_delay,
  output logic             en_measure,
  output logic             en_score,
  output logic             en_foul,
  output logic             stim_led,
  output logic [BCD_W-1:0] score_a,
  output logic [BCD_W-1:0] score_b,
  output logic [BCD_W-1:0] score_c,
  output logic             false_start
);

  localparam int DIV_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(TICK_DIV - 1);
  localparam logic [15:0] D_MIN =
    16'(DELAY_MIN_MS);
  localparam logic [15:0] S_HOLD =
    16'(SCORE_HOLD_MS);
  localparam logic [15:0] F_HOLD =
    16'(FOUL_HOLD_MS);

  state_t state;
  state_t next;

  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] s3;
  logic       start_p;
  logic       abort_p;

  logic [DIV_W-1:0] div;
  logic             tick;

  logic [15:0] ms_cnt;
  logic [15:0] lfsr;
  logic [15:0] delay_target;

  logic entry;
  logic sc_clr;
  logic sc_inc;

  assign out_state = state;
  assign tick      = (div == DIV_LAST);
  assign entry     = (next != state);

  // Two-flop synchronizer plus registered
  // falling-edge pulse (buttons idle high)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 2'b11;
      s2      <= 2'b11;
      s3      <= 2'b11;
      start_p <= 1'b0;
      abort_p <= 1'b0;
    end else begin
      s1      <= KEY;
      s2      <= s1;
      s3      <= s2;
      start_p <= s3[0] & ~s2[0];
      abort_p <= s3[1] & ~s2[1];
    end
  end

  // Free-running ms divider, ignores state
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Pseudo-random source, steps every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Per-state ms counter, cleared on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt <= '0;
    end else if (entry) begin
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= ms_cnt + 16'd1;
    end
  end

  // Latch the random delay as DELAY is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_target <= '0;
    end else if (state == ST_IDLE &&
                 next == ST_DELAY) begin
      delay_target <= D_MIN +
                      (lfsr & 16'h07FF);
    end
  end

  // Next-state logic; abort overrides all
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: begin
        if (start_p) next = ST_DELAY;
      end
      ST_DELAY: begin
        if (start_p) begin
          next = ST_FOUL;
        end else if (ms_cnt == delay_target) begin
          next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (start_p) next = ST_SCORE;
      end
      ST_SCORE: begin
        if (ms_cnt == S_HOLD) next = ST_IDLE;
      end
      ST_FOUL: begin
        if (ms_cnt == F_HOLD) next = ST_IDLE;
      end
      default: begin
        next = ST_IDLE;
      end
    endcase
    if (abort_p && state != ST_IDLE) begin
      next = ST_IDLE;
    end
  end

  // State register and registered decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      en_idle     <= 1'b1;
      en_delay    <= 1'b0;
      en_measure  <= 1'b0;
      en_score    <= 1'b0;
      en_foul     <= 1'b0;
      stim_led    <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= next;
      en_idle     <= (next == ST_IDLE);
      en_delay    <= (next == ST_DELAY);
      en_measure  <= (next == ST_MEASURE);
      en_score    <= (next == ST_SCORE);
      en_foul     <= (next == ST_FOUL);
      stim_led    <= (next == ST_MEASURE);
      false_start <= (next == ST_FOUL);
    end
  end

  assign sc_clr = (next == ST_MEASURE) &&
                  (state != ST_MEASURE);
  assign sc_inc = tick &&
                  (state == ST_MEASURE);

  bcd_counter3 u_score (
    .clk (clk),
    .rst (rst),
    .clr (sc_clr),
    .inc (sc_inc),
    .d0  (score_a),
    .d1  (score_b),
    .d2  (score_c)
  );

endmodule
